program_memory_loader: RTL and testbench

Parametrised, loadable instruction memory for the BIP datapath. It holds `N_INSTRUCTIONS` words of `NB_INSTRUCTION` bits and serves a registered fetch port to the CPU. A byte-stream load port, typically driven by the UART receiver, fills the memory through a small loader FSM. The block replaces the fixed, combinational-read program memory, so programs can be rewritten at run time without resynthesis.

---
 rtl/program_memory_loader.sv | 160 ++++++++++++++++
 tb/tb_program_memory_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// program_memory_loader
// Loadable instruction memory for the BIP datapath. A byte stream (MSB-first,
// BPW bytes per word) is assembled into words and written sequentially from
// word 0 by a small IDLE/LOAD/DONE loader FSM. The CPU fetch port is
// registered (1-cycle latency) and returns NOP while a load is in progress.
//
// Ports:
//   i_clock, i_reset_n              clock, asynchronous active-low reset
//   i_load_start, i_load_stop       load control pulses (start wins over stop)
//   i_byte_valid, i_byte            load byte stream
//   o_byte_ready, o_busy            loader is in LOAD (registered decode)
//   o_load_done, o_load_count       sticky completion flag, words written
//   i_fetch_en, i_address           fetch request and word address
//   o_instruction, o_addr_oob       registered fetched word, out-of-range flag
module program_memory_loader #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDRESS     = 11,
  parameter int N_INSTRUCTIONS = 16,
  parameter int NB_BYTE        = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_load_start,
  input  logic                      i_load_stop,
  input  logic                      i_byte_valid,
  input  logic [NB_BYTE-1:0]        i_byte,
  output logic                      o_byte_ready,
  output logic                      o_busy,
  output logic                      o_load_done,
  output logic [NB_ADDRESS:0]       o_load_count,
  input  logic                      i_fetch_en,
  input  logic [NB_ADDRESS-1:0]     i_address,
  output logic [NB_INSTRUCTION-1:0] o_instruction,
  output logic                      o_addr_oob
);

  localparam int BPW      = NB_INSTRUCTION / NB_BYTE;
  localparam int NB_IDX   = (N_INSTRUCTIONS > 1) ? $clog2(N_INSTRUCTIONS) : 1;
  localparam int NB_BCNT  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NB_SHIFT = (BPW > 1) ? (NB_INSTRUCTION - NB_BYTE) : 1;

  localparam logic [NB_BCNT-1:0]  LAST_BYTE  = NB_BCNT'(BPW - 1);
  localparam logic [NB_ADDRESS:0] LAST_WORD  = (NB_ADDRESS + 1)'(N_INSTRUCTIONS - 1);
  localparam logic [NB_ADDRESS:0] DEPTH      = (NB_ADDRESS + 1)'(N_INSTRUCTIONS);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [NB_BCNT-1:0]          byte_cnt_reg, byte_cnt_next;
  logic [NB_SHIFT-1:0]         shift_reg, shift_next;
  logic [NB_ADDRESS:0]         count_reg, count_next;
  logic                        done_reg, done_next;
  logic                        ready_reg;
  logic                        write_en;
  logic [NB_INSTRUCTION-1:0]   assembled;

  logic [NB_INSTRUCTION-1:0]   mem [N_INSTRUCTIONS];

  // Earlier bytes sit in the shift register, so the newest byte always lands
  // in the low byte and the first byte of a word ends up in the top byte.
  generate
    if (BPW == 1) begin : g_single
      assign assembled = i_byte;
    end else begin : g_multi
      assign assembled = {shift_reg, i_byte};
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    count_next    = count_reg;
    done_next     = done_reg;
    write_en      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (i_load_start) begin
          state_next    = LOAD;
          byte_cnt_next = '0;
          count_next    = '0;
          done_next     = 1'b0;
        end
      end
      LOAD: begin
        if (i_load_start) begin
          // Restart: partial word and any same-cycle byte/stop are dropped.
          byte_cnt_next = '0;
          count_next    = '0;
        end else if (i_load_stop) begin
          state_next    = DONE;
          byte_cnt_next = '0;
          done_next     = 1'b1;
        end else if (i_byte_valid) begin
          if (byte_cnt_reg == LAST_BYTE) begin
            write_en      = 1'b1;
            byte_cnt_next = '0;
            count_next    = count_reg + 1'b1;
            if (count_reg == LAST_WORD) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
            shift_next    = assembled[NB_SHIFT-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      count_reg    <= count_next;
      done_reg     <= done_next;
      // Registered decode of the state being entered, so ready/busy track
      // the LOAD state exactly without a combinational path from inputs.
      ready_reg    <= (state_next == LOAD);
    end
  end

  // Contents survive reset, so the array has no reset term.
  always_ff @(posedge i_clock) begin
    if (write_en) begin
      mem[count_reg[NB_IDX-1:0]] <= assembled;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instruction <= '0;
      o_addr_oob    <= 1'b0;
    end else if (i_fetch_en) begin
      if (state_reg == LOAD) begin
        o_instruction <= '0;
        o_addr_oob    <= 1'b0;
      end else begin
        o_instruction <= mem[i_address[NB_IDX-1:0]];
        o_addr_oob    <= ({1'b0, i_address} >= DEPTH);
      end
    end
  end

  assign o_byte_ready = ready_reg;
  assign o_busy       = ready_reg;
  assign o_load_done  = done_reg;
  assign o_load_count = count_reg;

endmodule

// File: tb/tb_program_memory_loader.sv
module tb_program_memory_loader;

  localparam int NI = 16;
  localparam int NA = 11;
  localparam int N  = 16;
  localparam int NB = 8;
  localparam int BPW = NI / NB;

  logic          i_clock;
  logic          i_reset_n;
  logic          i_load_start;
  logic          i_load_stop;
  logic          i_byte_valid;
  logic [NB-1:0] i_byte;
  logic          o_byte_ready;
  logic          o_busy;
  logic          o_load_done;
  logic [NA:0]   o_load_count;
  logic          i_fetch_en;
  logic [NA-1:0] i_address;
  logic [NI-1:0] o_instruction;
  logic          o_addr_oob;

  program_memory_loader #(
    .NB_INSTRUCTION(NI), .NB_ADDRESS(NA), .N_INSTRUCTIONS(N), .NB_BYTE(NB)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_load_start(i_load_start), .i_load_stop(i_load_stop),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(o_byte_ready), .o_busy(o_busy),
    .o_load_done(o_load_done), .o_load_count(o_load_count),
    .i_fetch_en(i_fetch_en), .i_address(i_address),
    .o_instruction(o_instruction), .o_addr_oob(o_addr_oob)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model: a loader is either collecting bytes or not; bytes are
  // gathered in a queue and packed into a word once BPW have arrived.
  bit          m_loading;
  logic [7:0]  m_bytes[$];
  int          m_count;
  bit          m_done;
  logic [15:0] m_mem [N];
  bit          m_written [N];
  logic [15:0] m_instr;
  bit          m_instr_known;
  bit          m_oob;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 0;
    m_bytes.delete();
    m_count = 0;
    m_done = 0;
    m_instr = '0;
    m_instr_known = 1;
    m_oob = 0;
  endtask

  task automatic model_edge(input bit start, input bit stop, input bit valid,
                            input logic [7:0] b, input bit fen, input int addr);
    if (fen) begin
      if (m_loading) begin
        m_instr = '0;
        m_instr_known = 1;
        m_oob = 0;
      end else begin
        m_instr = m_mem[addr % N];
        m_instr_known = m_written[addr % N];
        m_oob = (addr >= N);
      end
    end
    if (start) begin
      m_loading = 1;
      m_bytes.delete();
      m_count = 0;
      m_done = 0;
    end else if (m_loading) begin
      if (stop) begin
        m_loading = 0;
        m_done = 1;
        m_bytes.delete();
      end else if (valid) begin
        m_bytes.push_back(b);
        if (m_bytes.size() == BPW) begin
          m_mem[m_count] = {m_bytes[0], m_bytes[1]};
          m_written[m_count] = 1;
          m_count++;
          m_bytes.delete();
          if (m_count == N) begin
            m_loading = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", 32'(o_busy), 32'(m_loading));
    check("byte_ready", 32'(o_byte_ready), 32'(m_loading));
    check("load_done", 32'(o_load_done), 32'(m_done));
    check("load_count", 32'(o_load_count), 32'(m_count));
    check("addr_oob", 32'(o_addr_oob), 32'(m_oob));
    if (m_instr_known) check("instruction", 32'(o_instruction), 32'(m_instr));
  endtask

  // One clock cycle: drive, clock, update model, compare.
  task automatic cyc(input bit start, input bit stop, input bit valid,
                     input logic [7:0] b, input bit fen, input int addr);
    i_load_start = start;
    i_load_stop  = stop;
    i_byte_valid = valid;
    i_byte       = b;
    i_fetch_en   = fen;
    i_address    = NA'(addr);
    @(posedge i_clock);
    model_edge(start, stop, valid, b, fen, addr);
    #1;
    check_outputs();
    $display("cycle t=%0t start=%0b stop=%0b valid=%0b byte=%02h fetch=%0b addr=%03h -> instr=%04h oob=%0b busy=%0b done=%0b count=%0d",
             $time, start, stop, valid, b, fen, addr, o_instruction, o_addr_oob, o_busy, o_load_done, o_load_count);
  endtask

  task automatic async_reset();
    i_load_start = 0; i_load_stop = 0; i_byte_valid = 0; i_fetch_en = 0;
    #1 i_reset_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    $display("reset asserted t=%0t busy=%0b count=%0d", $time, o_busy, o_load_count);
    @(posedge i_clock);
    #2 i_reset_n = 1'b1;
  endtask

  task automatic fetch(input int addr);
    cyc(0, 0, 0, 8'h00, 1, addr);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(0, 0, 1, b, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 'x;
      m_written[i] = 0;
    end
    i_reset_n = 1'b0;
    i_load_start = 0; i_load_stop = 0; i_byte_valid = 0;
    i_byte = '0; i_fetch_en = 0; i_address = '0;
    repeat (3) @(posedge i_clock);
    #1;
    model_reset();
    check_outputs();
    check("reset_instruction", 32'(o_instruction), 32'h0);
    #2 i_reset_n = 1'b1;
    cyc(0, 0, 0, 8'h00, 0, 0);

    // Full load: 0x12,0x34,0x56,0x78,... for 32 bytes.
    cyc(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < N * BPW; i++) send(8'(8'h12 + 8'h22 * i));
    check("full_done", 32'(o_load_done), 32'h1);
    check("full_count", 32'(o_load_count), 32'd16);
    fetch(0);
    check("fetch0", 32'(o_instruction), 32'h1234);
    fetch(1);
    check("fetch1", 32'(o_instruction), 32'h5678);
    for (int a = 0; a < N; a++) fetch(a);

    // Early stop after three bytes.
    cyc(1, 0, 0, 8'h00, 0, 0);
    send(8'hAB); send(8'hCD); send(8'hEF);
    cyc(0, 1, 0, 8'h00, 0, 0);
    check("stop_count", 32'(o_load_count), 32'd1);
    check("stop_done", 32'(o_load_done), 32'h1);
    fetch(0);
    check("stop_word0", 32'(o_instruction), 32'hABCD);
    fetch(1);
    check("stop_word1_kept", 32'(o_instruction), 32'h5678);

    // Address wrap.
    fetch(32'h013);
    check("wrap_oob", 32'(o_addr_oob), 32'h1);
    fetch(32'h003);
    check("inrange_oob", 32'(o_addr_oob), 32'h0);

    // Reset mid-load after five bytes.
    cyc(1, 0, 0, 8'h00, 0, 0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    async_reset();
    cyc(0, 0, 0, 8'h00, 0, 0);
    check("rst_busy", 32'(o_busy), 32'h0);
    fetch(0);
    check("rst_word0", 32'(o_instruction), 32'h1122);
    fetch(1);
    check("rst_word1", 32'(o_instruction), 32'h3344);
    cyc(1, 0, 0, 8'h00, 0, 0);
    send(8'h9A); send(8'hBC);
    cyc(0, 1, 0, 8'h00, 0, 0);
    fetch(0);
    check("newload_word0", 32'(o_instruction), 32'h9ABC);

    // Fetch during load, then start+stop+byte restart.
    cyc(1, 0, 0, 8'h00, 0, 0);
    fetch(2);
    check("fetch_in_load", 32'(o_instruction), 32'h0);
    send(8'hDE);
    cyc(1, 1, 1, 8'h77, 0, 0);
    check("restart_count", 32'(o_load_count), 32'd0);
    check("restart_busy", 32'(o_busy), 32'h1);
    send(8'h01); send(8'h02);
    cyc(0, 1, 0, 8'h00, 0, 0);
    fetch(0);
    check("restart_word0", 32'(o_instruction), 32'h0102);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 70, 8'($urandom),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 31)));
      end
    end
    // Settle into DONE and read everything back.
    cyc(0, 1, 0, 8'h00, 0, 0);
    for (int a = 0; a < 2 * N; a++) fetch(a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
